// File: rtl/hazard_unit_md_if.sv
// Pipeline-side signal bundle for hazard_unit_md: stage register fields in,
// stall/flush/forward controls and MULT/DIV tracker status out.
interface hazard_unit_md_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs_d_i;
  logic [REG_AW-1:0] rt_d_i;
  logic              branch_d_i;
  logic              pc_src_d_i;
  logic              jump_d_i;
  logic              hilo_read_d_i;
  logic              md_start_d_i;
  logic [REG_AW-1:0] rs_e_i;
  logic [REG_AW-1:0] rt_e_i;
  logic [REG_AW-1:0] write_reg_e_i;
  logic              mem_to_reg_e_i;
  logic              reg_write_e_i;
  logic              md_start_e_i;
  logic              md_op_e_i;
  logic [REG_AW-1:0] write_reg_m_i;
  logic              mem_to_reg_m_i;
  logic              reg_write_m_i;
  logic [REG_AW-1:0] write_reg_w_i;
  logic              reg_write_w_i;

  logic              stall_f_o;
  logic              stall_d_o;
  logic              flush_d_o;
  logic              flush_e_o;
  logic              forward_a_d_o;
  logic              forward_b_d_o;
  logic [1:0]        forward_a_e_o;
  logic [1:0]        forward_b_e_o;
  logic              md_busy_o;
  logic              md_done_o;

  modport master (
    output rs_d_i, rt_d_i, branch_d_i, pc_src_d_i, jump_d_i, hilo_read_d_i,
           md_start_d_i, rs_e_i, rt_e_i, write_reg_e_i, mem_to_reg_e_i,
           reg_write_e_i, md_start_e_i, md_op_e_i, write_reg_m_i,
           mem_to_reg_m_i, reg_write_m_i, write_reg_w_i, reg_write_w_i,
    input  stall_f_o, stall_d_o, flush_d_o, flush_e_o, forward_a_d_o,
           forward_b_d_o, forward_a_e_o, forward_b_e_o, md_busy_o, md_done_o
  );

  modport slave (
    input  rs_d_i, rt_d_i, branch_d_i, pc_src_d_i, jump_d_i, hilo_read_d_i,
           md_start_d_i, rs_e_i, rt_e_i, write_reg_e_i, mem_to_reg_e_i,
           reg_write_e_i, md_start_e_i, md_op_e_i, write_reg_m_i,
           mem_to_reg_m_i, reg_write_m_i, write_reg_w_i, reg_write_w_i,
    output stall_f_o, stall_d_o, flush_d_o, flush_e_o, forward_a_d_o,
           forward_b_d_o, forward_a_e_o, forward_b_e_o, md_busy_o, md_done_o
  );
endinterface

// File: rtl/hazard_unit_md.sv
// Hazard unit for the 5-stage MIPS pipeline with a multi-cycle MULT/DIV tracker.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/md-stall/flush counters.
module hazard_unit_md #(
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_unit_md_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt_o,
  output logic [31:0]         perf_md_stall_cnt_o,
  output logic [31:0]         perf_flush_cnt_o
`endif
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [REG_AW-1:0] ZERO      = '0;
  localparam logic [CW-1:0]     MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0]     DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e       state;
  logic [CW-1:0]   cnt;
  logic            md_done;
  logic            lw_stall;
  logic            branch_stall;
  logic            md_pending;
  logic            md_stall;
  logic            stall;
  logic            flush_d;

  always_comb begin
    hz.forward_a_e_o = 2'b00;
    if (hz.rs_e_i != ZERO && hz.rs_e_i == hz.write_reg_m_i && hz.reg_write_m_i)
      hz.forward_a_e_o = 2'b10;
    else if (hz.rs_e_i != ZERO && hz.rs_e_i == hz.write_reg_w_i && hz.reg_write_w_i)
      hz.forward_a_e_o = 2'b01;

    hz.forward_b_e_o = 2'b00;
    if (hz.rt_e_i != ZERO && hz.rt_e_i == hz.write_reg_m_i && hz.reg_write_m_i)
      hz.forward_b_e_o = 2'b10;
    else if (hz.rt_e_i != ZERO && hz.rt_e_i == hz.write_reg_w_i && hz.reg_write_w_i)
      hz.forward_b_e_o = 2'b01;
  end

  assign hz.forward_a_d_o = (hz.rs_d_i != ZERO) && (hz.rs_d_i == hz.write_reg_m_i) && hz.reg_write_m_i;
  assign hz.forward_b_d_o = (hz.rt_d_i != ZERO) && (hz.rt_d_i == hz.write_reg_m_i) && hz.reg_write_m_i;

  assign lw_stall = hz.mem_to_reg_e_i && (hz.rt_e_i != ZERO) &&
                    ((hz.rs_d_i == hz.rt_e_i) || (hz.rt_d_i == hz.rt_e_i));

  assign branch_stall = hz.branch_d_i &&
    ((hz.reg_write_e_i && (hz.write_reg_e_i != ZERO) &&
      ((hz.write_reg_e_i == hz.rs_d_i) || (hz.write_reg_e_i == hz.rt_d_i))) ||
     (hz.mem_to_reg_m_i && (hz.write_reg_m_i != ZERO) &&
      ((hz.write_reg_m_i == hz.rs_d_i) || (hz.write_reg_m_i == hz.rt_d_i))));

  // An op sitting in E this cycle counts as pending even before the FSM sees it,
  // so a reader in D cannot slip past while the tracker is still IDLE/DONE.
  assign md_pending = (state == BUSY) || hz.md_start_e_i;
  assign md_stall   = (hz.md_start_d_i && md_pending) ||
                      (hz.hilo_read_d_i && (md_pending || state == DONE));

  assign stall   = lw_stall || branch_stall || md_stall;
  assign flush_d = hz.pc_src_d_i || hz.jump_d_i;

  assign hz.stall_f_o = stall;
  assign hz.stall_d_o = stall;
  assign hz.flush_e_o = stall;
  assign hz.flush_d_o = flush_d;
  assign hz.md_busy_o = (state != IDLE);
  assign hz.md_done_o = md_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hz.md_start_e_i) begin
            cnt   <= hz.md_op_e_i ? DIV_LOAD : MULT_LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state   <= DONE;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (hz.md_start_e_i) begin
            cnt   <= hz.md_op_e_i ? DIV_LOAD : MULT_LOAD;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o    <= '0;
      perf_md_stall_cnt_o <= '0;
      perf_flush_cnt_o    <= '0;
    end else begin
      if (stall && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (md_stall && perf_md_stall_cnt_o != '1)
        perf_md_stall_cnt_o <= perf_md_stall_cnt_o + 32'd1;
      if (flush_d && perf_flush_cnt_o != '1)
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_md.sv
// Scoreboard bench for hazard_unit_md: per-cycle expected outputs come from a
// cycle-indexed behavioural model and are checked against the DUT each cycle.
module tb_hazard_unit_md;
  localparam int REG_AW      = 5;
  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_md_if #(.REG_AW(REG_AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_md_stall_cnt, perf_flush_cnt;
`endif

  hazard_unit_md #(
    .REG_AW(REG_AW),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz(hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_md_stall_cnt_o(perf_md_stall_cnt),
    .perf_flush_cnt_o(perf_flush_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic        flush_d;
    logic        fad;
    logic        fbd;
    logic [1:0]  fae;
    logic [1:0]  fbe;
    logic        busy;
    logic        done;
    logic [31:0] ps;
    logic [31:0] pm;
    logic [31:0] pf;
  } exp_t;

  exp_t sb[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // model: cycle of acceptance and cycle at which the done pulse is due
  int cyc      = 0;
  int acc_cyc  = -1;
  int done_cyc = -1;
  logic [31:0] m_ps = '0, m_pm = '0, m_pf = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
    if (src != 0 && src == hz.write_reg_m_i && hz.reg_write_m_i) return 2'b10;
    if (src != 0 && src == hz.write_reg_w_i && hz.reg_write_w_i) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic reg_hit(input logic [REG_AW-1:0] dst);
    return dst != 0 && (dst == hz.rs_d_i || dst == hz.rt_d_i);
  endfunction

  task automatic clear_inputs();
    hz.rs_d_i = '0; hz.rt_d_i = '0; hz.branch_d_i = 0; hz.pc_src_d_i = 0;
    hz.jump_d_i = 0; hz.hilo_read_d_i = 0; hz.md_start_d_i = 0;
    hz.rs_e_i = '0; hz.rt_e_i = '0; hz.write_reg_e_i = '0;
    hz.mem_to_reg_e_i = 0; hz.reg_write_e_i = 0; hz.md_start_e_i = 0;
    hz.md_op_e_i = 0; hz.write_reg_m_i = '0; hz.mem_to_reg_m_i = 0;
    hz.reg_write_m_i = 0; hz.write_reg_w_i = '0; hz.reg_write_w_i = 0;
  endtask

  // Inputs are already applied; push expectation, compare at negedge, advance model.
  task automatic step(input string tag);
    exp_t e, g;
    logic busy, done, pending, lw, br, mds;
    busy = (done_cyc >= 0) && (cyc > acc_cyc) && (cyc <= done_cyc);
    done = (cyc == done_cyc);
    pending = (busy && !done) || hz.md_start_e_i;
    mds = (hz.md_start_d_i && pending) || (hz.hilo_read_d_i && (pending || done));
    lw = hz.mem_to_reg_e_i && hz.rt_e_i != 0 &&
         (hz.rs_d_i == hz.rt_e_i || hz.rt_d_i == hz.rt_e_i);
    br = hz.branch_d_i && ((hz.reg_write_e_i && reg_hit(hz.write_reg_e_i)) ||
                           (hz.mem_to_reg_m_i && reg_hit(hz.write_reg_m_i)));
    e.tag     = tag;
    e.stall   = lw || br || mds;
    e.flush_d = hz.pc_src_d_i || hz.jump_d_i;
    e.fad     = hz.rs_d_i != 0 && hz.rs_d_i == hz.write_reg_m_i && hz.reg_write_m_i;
    e.fbd     = hz.rt_d_i != 0 && hz.rt_d_i == hz.write_reg_m_i && hz.reg_write_m_i;
    e.fae     = fwd_e(hz.rs_e_i);
    e.fbe     = fwd_e(hz.rt_e_i);
    e.busy    = busy;
    e.done    = done;
    e.ps = m_ps; e.pm = m_pm; e.pf = m_pf;
    sb.push_back(e);

    @(negedge clk);
    g = sb.pop_front();
    check({g.tag, ".stall_f"}, 32'(hz.stall_f_o), 32'(g.stall));
    check({g.tag, ".stall_d"}, 32'(hz.stall_d_o), 32'(g.stall));
    check({g.tag, ".flush_e"}, 32'(hz.flush_e_o), 32'(g.stall));
    check({g.tag, ".flush_d"}, 32'(hz.flush_d_o), 32'(g.flush_d));
    check({g.tag, ".fwd_a_d"}, 32'(hz.forward_a_d_o), 32'(g.fad));
    check({g.tag, ".fwd_b_d"}, 32'(hz.forward_b_d_o), 32'(g.fbd));
    check({g.tag, ".fwd_a_e"}, 32'(hz.forward_a_e_o), 32'(g.fae));
    check({g.tag, ".fwd_b_e"}, 32'(hz.forward_b_e_o), 32'(g.fbe));
    check({g.tag, ".busy"},    32'(hz.md_busy_o), 32'(g.busy));
    check({g.tag, ".done"},    32'(hz.md_done_o), 32'(g.done));
`ifdef HAZARD_PERF_CNT_EN
    check({g.tag, ".perf_stall"}, perf_stall_cnt, g.ps);
    check({g.tag, ".perf_md"},    perf_md_stall_cnt, g.pm);
    check({g.tag, ".perf_flush"}, perf_flush_cnt, g.pf);
`endif

    if (rst) begin
      acc_cyc = -1; done_cyc = -1;
      m_ps = '0; m_pm = '0; m_pf = '0;
    end else begin
      if ((!busy || done) && hz.md_start_e_i) begin
        acc_cyc  = cyc;
        done_cyc = cyc + (hz.md_op_e_i ? DIV_CYCLES : MULT_CYCLES);
      end
      if (e.stall   && m_ps != 32'hFFFF_FFFF) m_ps = m_ps + 1;
      if (mds       && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
      if (e.flush_d && m_pf != 32'hFFFF_FFFF) m_pf = m_pf + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;
    step("idle_zero");

    // E/D forwarding priority and register 0
    hz.rs_e_i = 5; hz.rt_e_i = 5; hz.write_reg_m_i = 5; hz.write_reg_w_i = 5;
    hz.reg_write_m_i = 1; hz.reg_write_w_i = 1; hz.rs_d_i = 5; hz.rt_d_i = 6;
    step("fwd_m");
    hz.reg_write_m_i = 0;
    step("fwd_w");
    hz.rs_e_i = 0; hz.rt_e_i = 7; hz.write_reg_w_i = 7;
    step("fwd_zero");
    hz.write_reg_m_i = 0; hz.reg_write_m_i = 1; hz.rs_d_i = 0; hz.rt_e_i = 0;
    step("fwd_r0_m");
    clear_inputs();

    // load-use
    hz.mem_to_reg_e_i = 1; hz.rt_e_i = 8; hz.rs_d_i = 8;
    step("lw_rs");
    hz.rs_d_i = 0; hz.rt_d_i = 8;
    step("lw_rt");
    hz.rt_e_i = 0; hz.rt_d_i = 0;
    step("lw_r0");
    clear_inputs();

    // branch stalls and flushes
    hz.branch_d_i = 1; hz.reg_write_e_i = 1; hz.write_reg_e_i = 3; hz.rs_d_i = 3;
    step("br_e");
    hz.write_reg_e_i = 0; hz.rs_d_i = 0;
    step("br_e_r0");
    hz.reg_write_e_i = 0; hz.mem_to_reg_m_i = 1; hz.write_reg_m_i = 9; hz.rt_d_i = 9;
    step("br_m");
    hz.branch_d_i = 0; hz.pc_src_d_i = 1;
    step("flush_pc");
    hz.pc_src_d_i = 0; hz.jump_d_i = 1; hz.mem_to_reg_e_i = 1; hz.rt_e_i = 9;
    step("flush_stall");
    clear_inputs();

    // MULT latency
    hz.md_start_e_i = 1; hz.md_op_e_i = 0;
    step("mult_acc");
    clear_inputs();
    for (int i = 0; i < MULT_CYCLES + 1; i++) step("mult_run");

    // MFHI held in D across a DIV
    hz.md_start_e_i = 1; hz.md_op_e_i = 1; hz.hilo_read_d_i = 1;
    step("div_hilo_acc");
    hz.md_start_e_i = 0; hz.md_op_e_i = 0;
    for (int i = 0; i < DIV_CYCLES + 1; i++) step("div_hilo");
    clear_inputs();

    // MULT in D while BUSY
    hz.md_start_e_i = 1;
    step("md_d_acc");
    hz.md_start_e_i = 0; hz.md_start_d_i = 1;
    for (int i = 0; i < MULT_CYCLES + 1; i++) step("md_d_busy");
    clear_inputs();

    // back-to-back: MULT then DIV accepted in DONE
    hz.md_start_e_i = 1;
    step("b2b_acc1");
    hz.md_start_e_i = 0;
    for (int i = 0; i < MULT_CYCLES - 1; i++) step("b2b_run1");
    hz.md_start_e_i = 1; hz.md_op_e_i = 1;
    step("b2b_acc2");
    clear_inputs();
    for (int i = 0; i < DIV_CYCLES + 1; i++) step("b2b_run2");

    // reset mid-DIV
    hz.md_start_e_i = 1; hz.md_op_e_i = 1; hz.jump_d_i = 1;
    step("rst_acc");
    clear_inputs();
    hz.hilo_read_d_i = 1;
    step("rst_busy");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < DIV_CYCLES + 2; i++) step("rst_after");
    clear_inputs();
    step("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
